fibo_req_scheduler: RTL and testbench

//  Shares one iterative Fibonacci datapath among N_REQ requesters.

---
 rtl/fibo_req_scheduler_pkg.sv | 18 +
 rtl/fibo_req_scheduler_step.sv | 54 +++++
 rtl/fibo_req_scheduler.sv | 158 +++++++++++++++
 tb/tb_fibo_req_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibo_req_scheduler_pkg.sv
// Shared definitions for the Fibonacci request scheduler and its datapath.
//   state_t         : scheduler FSM encoding (IDLE / RUN / DONE)
//   DEF_*           : default parameter values used by the modules
//   FIB_MAX_IDX_32  : largest n whose Fib(n) still fits in 32 bits
package fibo_req_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_IDX_W      = 6;
    localparam int FIB_MAX_IDX_32 = 47;

endpackage

// File: rtl/fibo_req_scheduler_step.sv
// fibo_step: iterative Fibonacci pair register with sticky overflow tracking.
// Holds a=Fib(k), b=Fib(k+1). 'load' restarts at k=0, 'step' advances k by one.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       restart the sequence (a=0, b=1, overflow flags cleared)
//   step       advance one term (ignored while load is high)
//   a          current term Fib(k), wrapped to WIDTH bits
//   ovf_a      1 when the true Fib(k) does not fit in WIDTH bits
module fibo_step
    import fibo_req_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             ovf_a
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             ovf_a_reg;
    logic             ovf_b_reg;
    logic [WIDTH:0]   sum_next;

    // One extra bit captures the carry-out of the wrapped addition.
    assign sum_next = {1'b0, a_reg} + {1'b0, b_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            ovf_a_reg <= 1'b0;
            ovf_b_reg <= 1'b0;
        end else if (load) begin
            a_reg     <= '0;
            b_reg     <= WIDTH'(1);
            ovf_a_reg <= 1'b0;
            ovf_b_reg <= 1'b0;
        end else if (step) begin
            a_reg     <= b_reg;
            b_reg     <= sum_next[WIDTH-1:0];
            ovf_a_reg <= ovf_b_reg;
            // Once any term has overflowed, every later term is too large as well.
            ovf_b_reg <= ovf_b_reg | ovf_a_reg | sum_next[WIDTH];
        end
    end

    assign a     = a_reg;
    assign ovf_a = ovf_a_reg;

endmodule

// File: rtl/fibo_req_scheduler.sv
// fibo_req_scheduler: round-robin sharing of one iterative Fibonacci datapath
// among N_REQ requesters, one job in flight, valid/ready response port.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req         per-requester request level
//   req_n       requested index, requester i at [i*IDX_W +: IDX_W]
//   gnt         one-hot single-cycle accept pulse
//   busy        high while a job is running or its result is pending
//   rsp_valid   result available; rsp_ready accepts it
//   rsp_id      requester owning the result
//   rsp_value   Fib(n) mod 2**WIDTH
//   rsp_ovf     true Fib(n) did not fit in WIDTH bits
module fibo_req_scheduler
    import fibo_req_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*IDX_W-1:0] req_n,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_value,
    output logic                   rsp_ovf
);

    localparam logic [ID_W:0]   NREQ_X = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    state_t             state_reg;
    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    id_reg;
    logic [IDX_W-1:0]   n_reg;
    logic [IDX_W-1:0]   k_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic               rsp_valid_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [WIDTH-1:0]   rsp_value_reg;
    logic               rsp_ovf_reg;

    logic [IDX_W-1:0]   req_n_arr [N_REQ];
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum_idx;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    ptr_next;
    logic               start;
    logic               step;
    logic [WIDTH-1:0]   fib_a;
    logic               fib_ovf_a;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_idx
            assign req_n_arr[gi] = req_n[gi*IDX_W +: IDX_W];
        end
    endgenerate

    // Rotate the request vector so the pointer position lands on bit 0; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign req_dbl = {req, req} >> ptr_reg;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                off = ID_W'(j);
            end
        end
        sum_idx = {1'b0, ptr_reg} + {1'b0, off};
        if (sum_idx >= NREQ_X) begin
            sum_idx = sum_idx - NREQ_X;
        end
        sel = sum_idx[ID_W-1:0];
    end

    assign ptr_next = (sel == LAST_ID) ? '0 : sel + 1'b1;
    assign start    = (state_reg == S_IDLE) && (|req);
    assign step     = (state_reg == S_RUN) && (k_reg != n_reg);

    fibo_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .clk   (clk),
        .rst   (rst),
        .load  (start),
        .step  (step),
        .a     (fib_a),
        .ovf_a (fib_ovf_a)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            n_reg         <= '0;
            k_reg         <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_value_reg <= '0;
            rsp_ovf_reg   <= 1'b0;
        end else begin
            gnt_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        gnt_reg   <= N_REQ'(1) << sel;
                        id_reg    <= sel;
                        n_reg     <= req_n_arr[sel];
                        k_reg     <= '0;
                        ptr_reg   <= ptr_next;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (k_reg == n_reg) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= id_reg;
                        rsp_value_reg <= fib_a;
                        rsp_ovf_reg   <= fib_ovf_a;
                        state_reg     <= S_DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    // New requests are deliberately ignored here; they are
                    // arbitrated in the IDLE cycle that follows the handshake.
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign busy      = (state_reg != S_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_value = rsp_value_reg;
    assign rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_fibo_req_scheduler.sv
// Self-checking bench for fibo_req_scheduler (N_REQ=4, WIDTH=32, IDX_W=6).
// Expected grants are queued by the stimulus; each observed grant moves a job
// onto the response scoreboard, and each response is compared with a 64-bit
// reference Fibonacci model.
module tb_fibo_req_scheduler;

    localparam int N_REQ = 4;
    localparam int WIDTH = 32;
    localparam int IDX_W = 6;

    typedef struct {
        int id;
        int n;
        int gcyc;
    } job_t;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*IDX_W-1:0] req_n;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [WIDTH-1:0]       rsp_value;
    logic                   rsp_ovf;

    int   assert_cnt = 0;
    int   fail_cnt   = 0;
    int   cyc        = 0;
    int   raise_cnt [N_REQ];
    int   gnt_cnt   [N_REQ];
    int   nt        [N_REQ];
    int   gq [$];
    job_t sb [$];
    job_t cur;

    logic             prev_valid;
    logic             prev_hold;
    logic             prev_hs;
    logic [1:0]       snap_id;
    logic [WIDTH-1:0] snap_val;
    logic             snap_ovf;

    fibo_req_scheduler #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_n     (req_n),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_value (rsp_value),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A requester holds its level until it has been granted.
    always_comb begin
        req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req[i] = (raise_cnt[i] != gnt_cnt[i]);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact Fib(n) in 64 bits (Fib(63) fits), then wrapped and flagged.
    function automatic logic [32:0] fib_model(input int n);
        longint unsigned f0 = 0;
        longint unsigned f1 = 1;
        longint unsigned t;
        for (int i = 0; i < n; i++) begin
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
        end
        return {(f0 >= 64'h1_0000_0000), f0[31:0]};
    endfunction

    // Response/grant monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [32:0] exp_r;
        job_t        j;
        if (rst) begin
            gq.delete();
            sb.delete();
            for (int i = 0; i < N_REQ; i++) gnt_cnt[i] = raise_cnt[i];
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) begin
                check("bubble_busy", 64'(busy), 64'd0);
                check("bubble_gnt", 64'(gnt), 64'd0);
            end
            if (gnt != '0) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (gnt[i]) gnt_cnt[i] = raise_cnt[i];
                end
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 64'(gnt), 64'd0);
                end else begin
                    j.id   = gq.pop_front();
                    j.n    = nt[j.id];
                    j.gcyc = cyc;
                    check("gnt", 64'(gnt), 64'(1) << j.id);
                    $display("grant id=%0d n=%0d cycle=%0d", j.id, j.n, cyc);
                    sb.push_back(j);
                end
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    cur   = sb.pop_front();
                    exp_r = fib_model(cur.n);
                    $display("rsp id=%0d n=%0d value=0x%08h ovf=%0d latency=%0d",
                             rsp_id, cur.n, rsp_value, rsp_ovf, cyc - cur.gcyc);
                    check("latency", 64'(cyc - cur.gcyc), 64'(cur.n + 1));
                    check("rsp_id", 64'(rsp_id), 64'(cur.id));
                    check("rsp_value", 64'(rsp_value), 64'(exp_r[31:0]));
                    check("rsp_ovf", 64'(rsp_ovf), 64'(exp_r[32]));
                end
            end
            if (prev_hold) begin
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_stable", {29'd0, rsp_ovf, rsp_id, rsp_value},
                      {29'd0, snap_ovf, snap_id, snap_val});
            end
            prev_hs    = rsp_valid && rsp_ready;
            prev_hold  = rsp_valid && !rsp_ready;
            prev_valid = rsp_valid;
            snap_id    = rsp_id;
            snap_val   = rsp_value;
            snap_ovf   = rsp_ovf;
        end
    end

    task automatic request(input int i, input int n);
        logic [IDX_W-1:0] nv;
        nv = n[IDX_W-1:0];
        req_n[i*IDX_W +: IDX_W] = nv;
        nt[i] = n;
        raise_cnt[i]++;
    endtask

    task automatic expect_grant(input int i);
        gq.push_back(i);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && req == '0 && gq.size() == 0 && sb.size() == 0)
                done = 1;
        end
        if (!done) check("timeout_idle", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_event_gnt(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (gnt != '0) done = 1;
        end
        if (!done) check("timeout_gnt", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_n     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            raise_cnt[i] = 0;
            nt[i]        = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_value", 64'(rsp_value), 64'd0);
        check("rst_ovf", 64'(rsp_ovf), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single job n=10 -> 55, latency 11
        expect_grant(0);
        request(0, 10);
        wait_idle(100);

        // 2: n=0 then n=1 back to back, one bubble between them
        expect_grant(1);
        expect_grant(2);
        request(1, 0);
        wait_event_gnt(20);
        @(posedge clk);
        #1 request(2, 1);
        wait_idle(100);

        // 3: overflow boundary for 32 bits
        expect_grant(3);
        expect_grant(0);
        request(3, 47);
        request(0, 48);
        wait_idle(300);

        // 4: round-robin order from reset, then pointer wrap
        do_reset();
        for (int i = 0; i < N_REQ; i++) expect_grant(i);
        for (int i = 0; i < N_REQ; i++) request(i, 3 + i);
        wait_idle(200);
        expect_grant(0);
        expect_grant(3);
        request(3, 1);
        request(0, 2);
        wait_idle(100);

        // 5: backpressure in DONE with req[2] pending
        rsp_ready = 1'b0;
        expect_grant(1);
        expect_grant(2);
        request(1, 4);
        request(2, 7);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        if (!seen) check("timeout_valid", 64'd1, 64'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_gnt", 64'(gnt), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("after_hs_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("after_hs_gnt2", 64'(gnt), 64'b0100);
        wait_idle(100);

        // 6: asynchronous reset in the middle of an n=30 job
        expect_grant(2);
        request(2, 30);
        repeat (6) @(posedge clk);
        #1;
        check("busy_before_rst", 64'(busy), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_gnt", 64'(gnt), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_value", 64'(rsp_value), 64'd0);
        check("arst_id", 64'(rsp_id), 64'd0);
        check("arst_ovf", 64'(rsp_ovf), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_grant(1);
        expect_grant(3);
        request(3, 2);
        request(1, 5);
        wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
